dbus_uncached_bridge: RTL and testbench
=======================================

Name: dbus_uncached_bridge

Overview:
- Sits directly downstream of the CPU data-bus slave port (read/write/address/byteenable/wrdata in, stall/rddata out).
- Converts uncached CPU data accesses into a single-outstanding valid/grant memory request channel.
- Stores are posted through a small FIFO write buffer; loads stall until the buffer drains, which preserves program order, and then complete with one memory read.

Parameters:
- WB_DEPTH, 4, write-buffer entries; power of two, >= 2.
- ADDR_WIDTH, 32, physical address width; addresses are 4-byte aligned.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- dbus_read  in  1  CPU load request; held stable while dbus_stall=1.
- dbus_write  in  1  CPU store request; held stable while dbus_stall=1.
- dbus_address  in  ADDR_WIDTH  aligned word address.
- dbus_byteenable  in  4  bit i enables wrdata[8i+7:8i].
- dbus_wrdata  in  32  store data.
- dbus_stall  out  1  request not yet complete.
- dbus_rddata  out  32  load data; valid in the cycle a read sees stall=0.
- mem_req  out  1  memory request valid.
- mem_we  out  1  1=write, 0=read.
- mem_addr  out  ADDR_WIDTH  request address.
- mem_be  out  4  request byte enables.
- mem_wdata  out  32  write data.
- mem_gnt  in  1  request accepted this cycle when mem_req=1.
- mem_rvalid  in  1  read data return (one per read, >=1 cycle after grant).
- mem_rdata  in  32  read data.

Behaviour:
- Reset (rst=1 at an edge): FSM=IDLE; FIFO emptied (count=0, pointers 0); rddata register=0. After reset: mem_req=0, dbus_stall=0, dbus_rddata=0.
- Reset mid-operation drops buffered writes and any in-flight read; a later mem_rvalid is ignored until a new read is issued.
- FIFO:
  - count is 0..WB_DEPTH; pointers wrap modulo WB_DEPTH.
  - Push: dbus_write=1, dbus_read=0, count<WB_DEPTH. Stores {address, byteenable, wrdata}.
  - Pop: FIFO head presented on mem with mem_gnt=1.
  - Simultaneous push and pop leaves count unchanged.
- Store handshake:
  - dbus_stall = dbus_write & (count==WB_DEPTH), combinational.
  - No full-bypass: a pop in the same cycle does not clear the stall.
  - The store is accepted in the first cycle with stall=0.
- Write drain:
  - While FSM is IDLE or DRAIN and count>0: mem_req=1, mem_we=1, and addr/be/wdata come from the FIFO head.
  - The head stays stable until mem_gnt. Writes get no response.
- Load FSM:
  - IDLE:
    - dbus_read=1 and count==0 -> RD_REQ, stall=1.
    - dbus_read=1 and count>0 -> DRAIN, stall=1.
  - DRAIN: stall=1; when count==0 after the edge -> RD_REQ.
  - RD_REQ: mem_req=1, mem_we=0, mem_addr=dbus_address, mem_be=dbus_byteenable, stall=1; on mem_gnt -> RD_WAIT.
  - RD_WAIT: mem_req=0, stall=1; on mem_rvalid, capture mem_rdata into the rddata register -> RESP.
  - RESP: stall=0, dbus_rddata=captured data; -> IDLE.
  - Minimum load latency (empty FIFO, immediate grant, rvalid the cycle after grant): read first seen in cycle 0, stall=0 in cycle 3.
- The read path never issues while count>0, so there is no read-after-write hazard check.
- dbus_read and dbus_write both 1: treated as a read; the store is not pushed.
- dbus_rddata holds its last captured value outside RESP.
- Invalidate signals are outside this block's scope and are not ports.

Test Plan:
1. Reset then idle -> mem_req=0, dbus_stall=0, dbus_rddata=0 for 10 cycles.
2. Single store to 0x1000_0040, be=4'b0011, data=0xDEAD_BEEF, mem_gnt=1 -> stall=0 in the request cycle; next cycle mem_req=1, mem_we=1 with identical fields; count returns to 0.
3. Five back-to-back stores with mem_gnt=0 (WB_DEPTH=4) -> the first four accepted without stall; the fifth stalls until mem_gnt=1 pops one; the mem write order equals the program order.
4. Two buffered stores, then a load from 0x1000_0080 -> stall=1 throughout; both writes granted first; only then a read request at 0x1000_0080; mem_rdata=0x1234_5678 appears as dbus_rddata with stall=0 in RESP.
5. Load with empty FIFO, gnt immediate, rvalid 1 cycle later -> stall=0 exactly 3 cycles after the read is first seen; rvalid delayed 5 cycles -> RESP delayed by 5.
6. rst asserted in RD_WAIT, then mem_rvalid pulses -> after reset stall=0, mem_req=0, rddata=0, no RESP; a subsequent load completes normally.

Source files
------------

// File: rtl/dbus_uncached_bridge_if.sv
// Bundle of the CPU data-bus slave port and the valid/grant memory channel.
// The bridge takes the slave view; the CPU/memory environment takes the master view.
interface dbus_uncached_bridge_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  dbus_read;
  logic                  dbus_write;
  logic [ADDR_WIDTH-1:0] dbus_address;
  logic [3:0]            dbus_byteenable;
  logic [31:0]           dbus_wrdata;
  logic                  dbus_stall;
  logic [31:0]           dbus_rddata;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [3:0]            mem_be;
  logic [31:0]           mem_wdata;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [31:0]           mem_rdata;

  modport slave (
    input  dbus_read, dbus_write, dbus_address, dbus_byteenable, dbus_wrdata,
    output dbus_stall, dbus_rddata,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport master (
    output dbus_read, dbus_write, dbus_address, dbus_byteenable, dbus_wrdata,
    input  dbus_stall, dbus_rddata,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/dbus_uncached_bridge.sv
// Uncached data-bus bridge: stores are posted through a FIFO write buffer,
// loads wait for the buffer to drain and then issue one memory read.
module dbus_uncached_bridge #(
  parameter int WB_DEPTH   = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  dbus_uncached_bridge_if.slave bus
);
  localparam int PTR_W = $clog2(WB_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WB_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    RD_REQ,
    RD_WAIT,
    RESP
  } state_e;

  state_e               state_q, state_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [31:0]          rddata_q, rddata_d;

  logic [ADDR_WIDTH-1:0] wb_addr_q [WB_DEPTH];
  logic [3:0]            wb_be_q   [WB_DEPTH];
  logic [31:0]           wb_data_q [WB_DEPTH];

  logic                  wb_empty, wb_full, push, pop, drain_active, load_stall;
  logic                  mem_req, mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [3:0]            mem_be;
  logic [31:0]           mem_wdata;

  assign wb_empty = (count_q == '0);
  assign wb_full  = (count_q == FULL_CNT);
  // A simultaneous read wins: the store half of a read+write request is dropped.
  assign push         = bus.dbus_write & ~bus.dbus_read & ~wb_full;
  assign drain_active = ((state_q == IDLE) || (state_q == DRAIN)) && !wb_empty;
  assign pop          = drain_active & bus.mem_gnt;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Buffer storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      wb_addr_q[wr_ptr_q] <= bus.dbus_address;
      wb_be_q[wr_ptr_q]   <= bus.dbus_byteenable;
      wb_data_q[wr_ptr_q] <= bus.dbus_wrdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rddata_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rddata_q <= rddata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rddata_d   = rddata_q;
    load_stall = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_be     = '0;
    mem_wdata  = '0;

    if (drain_active) begin
      mem_req   = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = wb_addr_q[rd_ptr_q];
      mem_be    = wb_be_q[rd_ptr_q];
      mem_wdata = wb_data_q[rd_ptr_q];
    end

    case (state_q)
      IDLE: begin
        if (bus.dbus_read) begin
          load_stall = 1'b1;
          state_d    = wb_empty ? RD_REQ : DRAIN;
        end
      end
      DRAIN: begin
        load_stall = 1'b1;
        if (count_d == '0) state_d = RD_REQ;
      end
      RD_REQ: begin
        load_stall = 1'b1;
        mem_req    = 1'b1;
        mem_we     = 1'b0;
        mem_addr   = bus.dbus_address;
        mem_be     = bus.dbus_byteenable;
        if (bus.mem_gnt) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        load_stall = 1'b1;
        if (bus.mem_rvalid) begin
          rddata_d = bus.mem_rdata;
          state_d  = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.dbus_stall  = load_stall | (bus.dbus_write & wb_full);
  assign bus.dbus_rddata = rddata_q;
  assign bus.mem_req     = mem_req;
  assign bus.mem_we      = mem_we;
  assign bus.mem_addr    = mem_addr;
  assign bus.mem_be      = mem_be;
  assign bus.mem_wdata   = mem_wdata;
endmodule

// File: tb/tb_dbus_uncached_bridge.sv
// Scoreboard bench for dbus_uncached_bridge: directed scenarios plus a random
// store/load mix checked against a program-order byte-addressed memory model.
module tb_dbus_uncached_bridge;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dbus_uncached_bridge_if #(.ADDR_WIDTH(32)) bus ();

  dbus_uncached_bridge #(.WB_DEPTH(4), .ADDR_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } mem_txn_t;

  mem_txn_t    exp_mem_q[$];
  logic [31:0] exp_rd_q[$];

  int checks   = 0;
  int failures = 0;

  logic [31:0] rmem [logic [31:0]];  // reference: program-order memory image
  logic [31:0] smem [logic [31:0]];  // memory seen by the slave model

  int gnt_mode = 1;  // 0 random, 1 always, 2 never
  int rv_delay = 1;  // 0 random 1..4, else fixed cycles after grant

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be,
                                        input logic [31:0] d);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return rmem.exists(a) ? rmem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] slv_read(input logic [31:0] a);
    return smem.exists(a) ? smem[a] : init_word(a);
  endfunction

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timeout, got no completion expected completion", name);
  endfunction

  // Memory slave: grant per gnt_mode, return read data rv_delay cycles after grant.
  initial begin : slave
    bit          rd_pending = 0;
    int          rd_cnt = 0;
    logic [31:0] rd_word = '0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (!rst && bus.mem_req && bus.mem_gnt) begin
        if (bus.mem_we) begin
          smem[bus.mem_addr] = merge(slv_read(bus.mem_addr), bus.mem_be, bus.mem_wdata);
        end else begin
          rd_pending = 1;
          rd_cnt     = (rv_delay == 0) ? int'($urandom_range(1, 4)) : rv_delay;
          rd_word    = slv_read(bus.mem_addr);
        end
      end
      @(posedge clk);
      #2;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = $urandom;
      if (rd_pending) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = rd_word;
          rd_pending     = 0;
        end
      end
      case (gnt_mode)
        0:       bus.mem_gnt = 1'($urandom_range(0, 1));
        1:       bus.mem_gnt = 1'b1;
        default: bus.mem_gnt = 1'b0;
      endcase
    end
  end

  // Monitor: every accepted memory request and every completed load is checked.
  initial begin : monitor
    mem_txn_t e;
    logic [31:0] er;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.mem_req && bus.mem_gnt) begin
          if (exp_mem_q.size() == 0) begin
            check("unexpected_mem_req", {31'd0, bus.mem_we, bus.mem_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            e = exp_mem_q.pop_front();
            check("mem_we", 64'(bus.mem_we), 64'(e.we));
            check("mem_addr", 64'(bus.mem_addr), 64'(e.addr));
            check("mem_be", 64'(bus.mem_be), 64'(e.be));
            if (e.we) check("mem_wdata", 64'(bus.mem_wdata), 64'(e.data));
            $display("[%0t] mem %s addr=%08h be=%b data=%08h", $time, e.we ? "WR" : "RD",
                     bus.mem_addr, bus.mem_be, bus.mem_wdata);
          end
        end
        if (bus.dbus_read && !bus.dbus_stall) begin
          if (exp_rd_q.size() == 0) begin
            check("unexpected_load_done", 64'(bus.dbus_rddata), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            er = exp_rd_q.pop_front();
            check("dbus_rddata", 64'(bus.dbus_rddata), 64'(er));
            $display("[%0t] load done addr=%08h rddata=%08h", $time, bus.dbus_address, bus.dbus_rddata);
          end
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d,
                          output int stall_cycles);
    bus.dbus_read       = 1'b0;
    bus.dbus_write      = 1'b1;
    bus.dbus_address    = a;
    bus.dbus_byteenable = be;
    bus.dbus_wrdata     = d;
    exp_mem_q.push_back('{we: 1'b1, addr: a, be: be, data: d});
    rmem[a] = merge(ref_read(a), be, d);
    stall_cycles = 0;
    forever begin
      @(negedge clk);
      if (!bus.dbus_stall) break;
      stall_cycles++;
      if (stall_cycles > 500) begin
        timeout("store_stall");
        break;
      end
    end
    next_cycle();
    bus.dbus_write = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [3:0] be, input bit also_write,
                         output int stall_cycles, output logic [31:0] data);
    bus.dbus_read       = 1'b1;
    bus.dbus_write      = also_write;
    bus.dbus_address    = a;
    bus.dbus_byteenable = be;
    bus.dbus_wrdata     = $urandom;
    exp_mem_q.push_back('{we: 1'b0, addr: a, be: be, data: 32'd0});
    exp_rd_q.push_back(ref_read(a));
    stall_cycles = 0;
    forever begin
      @(negedge clk);
      if (!bus.dbus_stall) break;
      stall_cycles++;
      if (stall_cycles > 500) begin
        timeout("load_stall");
        break;
      end
    end
    data = bus.dbus_rddata;
    next_cycle();
    bus.dbus_read  = 1'b0;
    bus.dbus_write = 1'b0;
  endtask

  task automatic wait_drained(input string name);
    int n = 0;
    while (exp_mem_q.size() != 0 && n < 2000) begin
      next_cycle();
      n++;
    end
    check(name, 64'(exp_mem_q.size()), 64'd0);
  endtask

  initial begin : stim
    int          sc;
    logic [31:0] rd;
    bus.dbus_read       = 1'b0;
    bus.dbus_write      = 1'b0;
    bus.dbus_address    = '0;
    bus.dbus_byteenable = '0;
    bus.dbus_wrdata     = '0;

    // 1: reset then idle
    repeat (3) next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_mem_req", 64'(bus.mem_req), 64'd0);
      check("idle_stall", 64'(bus.dbus_stall), 64'd0);
      check("idle_rddata", 64'(bus.dbus_rddata), 64'd0);
    end
    next_cycle();

    // 2: single posted store, immediate grant
    gnt_mode = 1;
    do_store(32'h1000_0040, 4'b0011, 32'hDEAD_BEEF, sc);
    check("single_store_stall_cycles", 64'(sc), 64'd0);
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("single_store_drained_req", 64'(bus.mem_req), 64'd0);
    next_cycle();

    // 3: fill the buffer with no grants; the fifth store waits for a pop
    gnt_mode = 2;
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      do_store(32'h1000_0100 + 32'(4 * i), 4'hF, 32'hA000_0000 + 32'(i), sc);
      check("fill_store_stall_cycles", 64'(sc), 64'd0);
    end
    fork
      do_store(32'h1000_0110, 4'b1100, 32'hA000_0004, sc);
      begin
        repeat (3) @(negedge clk);
        gnt_mode = 1;
      end
    join
    check("full_store_stall_cycles", 64'(sc), 64'd4);
    wait_drained("fill_drain_left");

    // 4: load behind two buffered stores
    smem[32'h1000_0080] = 32'h1234_5678;
    rmem[32'h1000_0080] = 32'h1234_5678;
    gnt_mode = 2;
    rv_delay = 1;
    next_cycle();
    do_store(32'h1000_0200, 4'hF, 32'h1111_2222, sc);
    check("buffered_store_stall_cycles", 64'(sc), 64'd0);
    do_store(32'h1000_0204, 4'b0101, 32'h3333_4444, sc);
    check("buffered_store_stall_cycles", 64'(sc), 64'd0);
    gnt_mode = 1;
    do_load(32'h1000_0080, 4'hF, 1'b0, sc, rd);
    check("load_after_drain_stall_cycles", 64'(sc), 64'd4);
    check("load_after_drain_data", 64'(rd), 64'h1234_5678);

    // 5: load latency with an empty buffer
    rv_delay = 1;
    do_load(32'h1000_0204, 4'hF, 1'b0, sc, rd);
    check("min_latency_stall_cycles", 64'(sc), 64'd3);
    rv_delay = 6;
    do_load(32'h1000_0200, 4'hF, 1'b0, sc, rd);
    check("slow_rvalid_stall_cycles", 64'(sc), 64'd8);

    // 6: reset while waiting for read data; the late rvalid must be ignored
    rv_delay = 5;
    bus.dbus_read       = 1'b1;
    bus.dbus_address    = 32'h1000_0300;
    bus.dbus_byteenable = 4'hF;
    exp_mem_q.push_back('{we: 1'b0, addr: 32'h1000_0300, be: 4'hF, data: 32'd0});
    repeat (3) next_cycle();
    rst            = 1'b1;
    bus.dbus_read  = 1'b0;
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_stall", 64'(bus.dbus_stall), 64'd0);
      check("post_rst_mem_req", 64'(bus.mem_req), 64'd0);
      check("post_rst_rddata", 64'(bus.dbus_rddata), 64'd0);
    end
    next_cycle();
    rv_delay = 2;
    do_load(32'h1000_0080, 4'hF, 1'b0, sc, rd);
    check("post_rst_load_stall_cycles", 64'(sc), 64'd4);

    // Random mix over a small address pool so loads hit earlier stores
    rv_delay = 0;
    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      logic [3:0]  be;
      gnt_mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
      repeat ($urandom_range(0, 2)) next_cycle();
      a  = 32'h2000_0000 + 32'(4 * $urandom_range(0, 7));
      be = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 9) < 6) begin
        do_store(a, be, $urandom, sc);
      end else begin
        do_load(a, be, ($urandom_range(0, 4) == 0), sc, rd);
      end
    end
    gnt_mode = 1;
    wait_drained("final_drain_left");
    check("final_loads_left", 64'(exp_rd_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end
endmodule
